// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared RV32I constants and helpers for the core front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;

    function automatic logic [XLEN-1:0] bswap32(input logic [XLEN-1:0] i_word);
        return {i_word[7:0], i_word[15:8], i_word[23:16], i_word[31:24]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ============================================================================
// Module      : fetch_hold_buf
// Description : One-entry {instr, pc} parking register used while ID stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_hold_buf #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_full
);

    logic        r_full_q,  w_full_d;
    logic [31:0] r_instr_q, w_instr_d;
    logic [31:0] r_pc_q,    w_pc_d;

    // Load wins over clear; the two never coincide in the fetch FSM.
    always_comb begin
        w_full_d  = r_full_q;
        w_instr_d = r_instr_q;
        w_pc_d    = r_pc_q;
        if (i_load) begin
            w_full_d  = 1'b1;
            w_instr_d = i_instr;
            w_pc_d    = i_pc;
        end else if (i_clear) begin
            w_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full_q  <= 1'b0;
            r_instr_q <= NOP_INSTR;
            r_pc_q    <= 32'h0;
        end else begin
            r_full_q  <= w_full_d;
            r_instr_q <= w_instr_d;
            r_pc_q    <= w_pc_d;
        end
    end

    assign o_instr = r_instr_q;
    assign o_pc    = r_pc_q;
    assign o_full  = r_full_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch stage with IF/ID pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = rv_pkg::NOP_INSTR,
    parameter bit          SWAP_BYTES = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ICACHE_ren,
    output logic        ICACHE_wen,
    output logic [29:0] ICACHE_addr,
    output logic [31:0] ICACHE_wdata,
    input  logic [31:0] ICACHE_rdata,
    input  logic        ICACHE_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    import rv_pkg::*;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_REDIR = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e          r_state_q,    w_state_d;
    logic [XLEN-1:0] r_pc_q,       w_pc_d;
    logic [XLEN-1:0] r_pend_pc_q,  w_pend_pc_d;
    logic            r_id_valid_q, w_id_valid_d;
    logic [XLEN-1:0] r_id_instr_q, w_id_instr_d;
    logic [XLEN-1:0] r_id_pc_q,    w_id_pc_d;

    logic            w_buf_load;
    logic            w_buf_clear;
    logic [XLEN-1:0] w_buf_instr;
    logic [XLEN-1:0] w_buf_pc;
    logic            w_buf_full;

    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_unused_redir_lo;

    assign w_rdata           = SWAP_BYTES ? bswap32(ICACHE_rdata) : ICACHE_rdata;
    assign w_redir_pc        = {redirect_pc[31:2], 2'b00};
    assign w_pc_plus4        = r_pc_q + 32'd4;
    assign w_unused_redir_lo = ^redirect_pc[1:0];

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_d       = r_pc_q;
        w_pend_pc_d  = r_pend_pc_q;
        w_id_valid_d = r_id_valid_q;
        w_id_instr_d = r_id_instr_q;
        w_id_pc_d    = r_id_pc_q;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;

        case (r_state_q)
            S_FETCH: begin
                if (redirect_valid && !ICACHE_stall) begin
                    w_pc_d       = w_redir_pc;
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP_INSTR;
                end else if (redirect_valid) begin
                    // Cache access is mid-flight: park the target until it completes.
                    w_pend_pc_d  = w_redir_pc;
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP_INSTR;
                    w_state_d    = S_REDIR;
                end else if (!ICACHE_stall && !id_stall) begin
                    w_id_valid_d = 1'b1;
                    w_id_instr_d = w_rdata;
                    w_id_pc_d    = r_pc_q;
                    w_pc_d       = w_pc_plus4;
                end else if (!ICACHE_stall) begin
                    w_buf_load   = 1'b1;
                    w_pc_d       = w_pc_plus4;
                    w_state_d    = S_HOLD;
                end else if (!id_stall) begin
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP_INSTR;
                end
            end

            S_REDIR: begin
                w_id_valid_d = 1'b0;
                w_id_instr_d = NOP_INSTR;
                if (redirect_valid) begin
                    w_pend_pc_d = w_redir_pc;
                end
                if (!ICACHE_stall) begin
                    w_pc_d    = redirect_valid ? w_redir_pc : r_pend_pc_q;
                    w_state_d = S_FETCH;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    w_buf_clear  = 1'b1;
                    w_pc_d       = w_redir_pc;
                    w_id_valid_d = 1'b0;
                    w_id_instr_d = NOP_INSTR;
                    w_state_d    = S_FETCH;
                end else if (!id_stall && w_buf_full) begin
                    w_buf_clear  = 1'b1;
                    w_id_valid_d = 1'b1;
                    w_id_instr_d = w_buf_instr;
                    w_id_pc_d    = w_buf_pc;
                    w_state_d    = S_FETCH;
                end
            end

            default: begin
                w_state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= S_FETCH;
            r_pc_q       <= RESET_PC;
            r_pend_pc_q  <= RESET_PC;
            r_id_valid_q <= 1'b0;
            r_id_instr_q <= NOP_INSTR;
            r_id_pc_q    <= 32'h0;
        end else begin
            r_state_q    <= w_state_d;
            r_pc_q       <= w_pc_d;
            r_pend_pc_q  <= w_pend_pc_d;
            r_id_valid_q <= w_id_valid_d;
            r_id_instr_q <= w_id_instr_d;
            r_id_pc_q    <= w_id_pc_d;
        end
    end

    fetch_hold_buf #(
        .NOP_INSTR (NOP_INSTR)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_instr (w_rdata),
        .i_pc    (r_pc_q),
        .o_instr (w_buf_instr),
        .o_pc    (w_buf_pc),
        .o_full  (w_buf_full)
    );

    // The request is gated by rst so it drops the instant reset asserts.
    assign ICACHE_ren   = !rst && (r_state_q != S_HOLD);
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_addr  = r_pc_q[31:2];
    assign ICACHE_wdata = 32'h0;

    assign id_valid     = r_id_valid_q;
    assign id_instr     = r_id_instr_q;
    assign id_pc        = r_id_pc_q;
    assign id_pc_plus4  = r_id_pc_q + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed, table-driven self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        ids;
        logic        e_ren;
        logic [29:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_ren;
    logic        icache_wen;
    logic [29:0] icache_addr;
    logic [31:0] icache_wdata;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ICACHE_ren     (icache_ren),
        .ICACHE_wen     (icache_wen),
        .ICACHE_addr    (icache_addr),
        .ICACHE_wdata   (icache_wdata),
        .ICACHE_rdata   (icache_rdata),
        .ICACHE_stall   (icache_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    // Each memory word encodes its own word address, stored big-endian.
    function automatic logic [31:0] iw(input logic [29:0] a);
        return {2'b11, a};
    endfunction

    always_comb begin
        logic [31:0] w;
        w = iw(icache_addr);
        icache_rdata = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic st,
                                input logic ids, input logic e_ren, input logic [29:0] e_addr,
                                input logic e_valid, input logic [31:0] e_instr,
                                input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st; v.ids = ids;
        v.e_ren = e_ren; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rpc, input logic st, input logic ids);
        redirect_valid = rv;
        redirect_pc    = rpc;
        icache_stall   = st;
        id_stall       = ids;
    endtask

    task automatic check_id(input string tag, input logic e_valid, input logic [31:0] e_instr,
                            input logic [31:0] e_pc);
        chk({tag, " id_valid"}, {31'b0, id_valid}, {31'b0, e_valid});
        chk({tag, " id_instr"}, id_instr, e_instr);
        if (e_valid) begin
            chk({tag, " id_pc"}, id_pc, e_pc);
            chk({tag, " id_pc_plus4"}, id_pc_plus4, e_pc + 32'd4);
        end
    endtask

    vec_t vecs[20];

    initial begin
        vecs[0]  = mk(0, 32'h0,         0, 0, 1, 30'h0,        1, iw(30'h0),        32'h0);
        vecs[1]  = mk(0, 32'h0,         0, 0, 1, 30'h1,        1, iw(30'h1),        32'h4);
        vecs[2]  = mk(0, 32'h0,         1, 0, 1, 30'h2,        0, c_nop,            32'h0);
        vecs[3]  = mk(0, 32'h0,         1, 0, 1, 30'h2,        0, c_nop,            32'h0);
        vecs[4]  = mk(0, 32'h0,         1, 0, 1, 30'h2,        0, c_nop,            32'h0);
        vecs[5]  = mk(0, 32'h0,         0, 0, 1, 30'h2,        1, iw(30'h2),        32'h8);
        vecs[6]  = mk(0, 32'h0,         0, 1, 1, 30'h3,        1, iw(30'h2),        32'h8);
        vecs[7]  = mk(0, 32'h0,         0, 1, 0, 30'h4,        1, iw(30'h2),        32'h8);
        vecs[8]  = mk(0, 32'h0,         0, 0, 0, 30'h4,        1, iw(30'h3),        32'hC);
        vecs[9]  = mk(0, 32'h0,         0, 0, 1, 30'h4,        1, iw(30'h4),        32'h10);
        vecs[10] = mk(1, 32'h103,       0, 0, 1, 30'h5,        0, c_nop,            32'h0);
        vecs[11] = mk(0, 32'h0,         0, 0, 1, 30'h40,       1, iw(30'h40),       32'h100);
        vecs[12] = mk(1, 32'h200,       1, 1, 1, 30'h41,       0, c_nop,            32'h0);
        vecs[13] = mk(1, 32'h300,       1, 0, 1, 30'h41,       0, c_nop,            32'h0);
        vecs[14] = mk(0, 32'h0,         1, 0, 1, 30'h41,       0, c_nop,            32'h0);
        vecs[15] = mk(0, 32'h0,         0, 0, 1, 30'h41,       0, c_nop,            32'h0);
        vecs[16] = mk(0, 32'h0,         0, 0, 1, 30'hC0,       1, iw(30'hC0),       32'h300);
        vecs[17] = mk(1, 32'hFFFF_FFFC, 0, 0, 1, 30'hC1,       0, c_nop,            32'h0);
        vecs[18] = mk(0, 32'h0,         0, 0, 1, 30'h3FFF_FFFF, 1, iw(30'h3FFF_FFFF), 32'hFFFF_FFFC);
        vecs[19] = mk(0, 32'h0,         0, 0, 1, 30'h0,        1, iw(30'h0),        32'h0);

        rst = 1'b1;
        drive(0, 32'h0, 0, 0);

        // Reset state
        @(posedge clk); #1;
        chk("reset ren", {31'b0, icache_ren}, 32'h0);
        chk("reset wen", {31'b0, icache_wen}, 32'h0);
        chk("reset id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset id_instr", id_instr, c_nop);
        chk("reset id_pc", id_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table: one row per clock
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            drive(vecs[i].rv, vecs[i].rpc, vecs[i].st, vecs[i].ids);
            #1;
            chk({tag, " ren"}, {31'b0, icache_ren}, {31'b0, vecs[i].e_ren});
            if (vecs[i].e_ren)
                chk({tag, " addr"}, {2'b0, icache_addr}, {2'b0, vecs[i].e_addr});
            @(posedge clk); #1;
            check_id(tag, vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc);
        end

        // Redirect and id_stall together while parked in HOLD: buffer dropped
        drive(0, 32'h0, 0, 1);
        @(posedge clk); #1;
        check_id("hold_enter", 1'b1, iw(30'h0), 32'h0);
        drive(1, 32'h400, 0, 1);
        #1;
        chk("hold ren", {31'b0, icache_ren}, 32'h0);
        @(posedge clk); #1;
        check_id("hold_redir", 1'b0, c_nop, 32'h0);
        drive(0, 32'h0, 0, 0);
        #1;
        chk("after_hold ren", {31'b0, icache_ren}, 32'h1);
        chk("after_hold addr", {2'b0, icache_addr}, 32'h100);
        @(posedge clk); #1;
        check_id("after_hold", 1'b1, iw(30'h100), 32'h400);

        // Asynchronous reset in the middle of a cache stall
        drive(0, 32'h0, 1, 0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst ren", {31'b0, icache_ren}, 32'h0);
        chk("arst id_valid", {31'b0, id_valid}, 32'h0);
        chk("arst id_instr", id_instr, c_nop);
        chk("arst id_pc", id_pc, 32'h0);
        chk("arst addr", {2'b0, icache_addr}, 32'h0);
        drive(0, 32'h0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst ren", {31'b0, icache_ren}, 32'h1);
        chk("post_rst addr", {2'b0, icache_addr}, 32'h0);
        @(posedge clk); #1;
        check_id("post_rst", 1'b1, iw(30'h0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
